// File: rtl/dmem_pkg.sv
// Shared types and MMIO constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  typedef enum logic [1:0] {SRC_ZERO, SRC_ARR, SRC_MMIO} src_e;

  localparam logic [31:0] MTIME_ADDR    = 32'hFFFF_FF00;
  localparam logic [31:0] MTIMECMP_ADDR = 32'hFFFF_FF04;
  localparam logic [31:0] MTIMECMP_RST  = 32'hFFFF_FFFF;
endpackage

// File: rtl/dmem_array.sv
// Single-port word-wide synchronous RAM; read data is registered and held
// until the next read enable.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency reads, posted writes, stall to core.
// Optional mtime/mtimecmp timer enabled by DMEM_MMIO_TIMER_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_read_vd,
  output logic        o_stall,
  output logic        o_err,
  output logic        o_interrupt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e        state, nxt_state;
  src_e          in_src, lat_src, out_src;
  logic [3:0]    cnt;
  logic [AW-1:0] in_idx, lat_idx, ram_addr;
  logic          in_range, is_mmio, acc_rd, ram_we, ram_re;
  logic [31:0]   ram_q, mmio_rd, mmio_q;
  logic          unused_lsb;

  assign unused_lsb = ^i_addr[1:0];
  assign in_idx     = i_addr[AW+1:2];
  assign in_range   = i_addr[31:2] < 30'(DEPTH);
  assign in_src     = in_range ? SRC_ARR : (is_mmio ? SRC_MMIO : SRC_ZERO);
  assign acc_rd     = (state == IDLE) && i_read_en && !i_write_en;
  // RAM reads once, on the edge entering DONE; in IDLE the live address is
  // used so LATENCY==1 works before the index has been latched.
  assign ram_addr   = (state == IDLE) ? in_idx : lat_idx;
  assign ram_re     = (nxt_state == DONE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (acc_rd) nxt_state = (LATENCY == 1) ? DONE : WAIT;
      WAIT:    if (cnt == 4'd1) nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    o_stall   = 1'b0;
    o_read_vd = 1'b0;
    o_err     = 1'b0;
    ram_we    = 1'b0;
    case (state)
      IDLE: begin
        o_stall = i_read_en;
        ram_we  = i_write_en && in_range;
        o_err   = (i_read_en || i_write_en) &&
                  (!(in_range || is_mmio) || (i_read_en && i_write_en));
      end
      WAIT:    o_stall = 1'b1;
      DONE:    o_read_vd = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      out_src <= SRC_ZERO;
    end else begin
      if (acc_rd) begin
        cnt     <= 4'(LATENCY - 1);
        lat_idx <= in_idx;
        lat_src <= in_src;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (ram_re) begin
        out_src <= (state == IDLE) ? in_src : lat_src;
        mmio_q  <= mmio_rd;
      end
    end
  end

  always_comb begin
    case (out_src)
      SRC_ARR:  o_read_data = ram_q;
      SRC_MMIO: o_read_data = mmio_q;
      default:  o_read_data = '0;
    endcase
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (i_write_data),
    .rdata (ram_q)
  );

`ifdef DMEM_MMIO_TIMER_EN
  logic        is_mtime, is_mtimecmp, lat_cmp, mmio_we, irq;
  logic [31:0] mtime, mtimecmp;

  assign is_mtime    = i_addr[31:2] == MTIME_ADDR[31:2];
  assign is_mtimecmp = i_addr[31:2] == MTIMECMP_ADDR[31:2];
  assign is_mmio     = is_mtime || is_mtimecmp;
  assign mmio_we     = (state == IDLE) && i_write_en;
  assign mmio_rd     = ((state == IDLE) ? is_mtimecmp : lat_cmp) ? mtimecmp : mtime;
  assign o_interrupt = irq;

  always_ff @(posedge clk) begin
    if (acc_rd) lat_cmp <= is_mtimecmp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      irq      <= 1'b0;
    end else begin
      irq   <= mtime >= mtimecmp;
      mtime <= (mmio_we && is_mtime) ? i_write_data : mtime + 32'd1;
      if (mmio_we && is_mtimecmp) mtimecmp <= i_write_data;
    end
  end
`else
  assign is_mmio     = 1'b0;
  assign mmio_rd     = '0;
  assign o_interrupt = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder at LATENCY=2 (index 0), one at LATENCY=1 (index 1).
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        re[2], we[2], vd[2], stall[2], err[2], irq[2];
  logic [31:0] addr[2], wd[2], rdata[2];
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .i_read_en(re[0]), .i_write_en(we[0]), .i_addr(addr[0]),
    .i_write_data(wd[0]), .o_read_data(rdata[0]), .o_read_vd(vd[0]), .o_stall(stall[0]),
    .o_err(err[0]), .o_interrupt(irq[0]));

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .i_read_en(re[1]), .i_write_en(we[1]), .i_addr(addr[1]),
    .i_write_data(wd[1]), .o_read_data(rdata[1]), .o_read_vd(vd[1]), .o_stall(stall[1]),
    .o_err(err[1]), .o_interrupt(irq[1]));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(int d, logic [31:0] a, logic [31:0] data, logic e);
    re[d] = 1'b0; we[d] = 1'b1; addr[d] = a; wd[d] = data;
    @(negedge clk);
    chk($sformatf("wr%0d_stall", d), stall[d], 0);
    chk($sformatf("wr%0d_err", d), err[d], e);
    @(posedge clk); #1;
    we[d] = 1'b0;
  endtask

  task automatic rd(int d, logic [31:0] a, int lat, logic [31:0] exp, logic e);
    we[d] = 1'b0; re[d] = 1'b1; addr[d] = a;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      chk($sformatf("rd%0d_stall_c%0d", d, c), stall[d], 1);
      chk($sformatf("rd%0d_vd_c%0d", d, c), vd[d], 0);
      if (c == 0) chk($sformatf("rd%0d_err", d), err[d], e);
      @(posedge clk); #1;
      addr[d] = a ^ 32'h40;  // latched address must be used from here on
    end
    @(negedge clk);
    chk($sformatf("rd%0d_vd", d), vd[d], 1);
    chk($sformatf("rd%0d_data@%h", d, a), rdata[d], exp);
    chk($sformatf("rd%0d_done_stall", d), stall[d], 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(int d, int n);
    re[d] = 1'b0; we[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_vd", d), vd[d], 0);
      chk($sformatf("idle%0d_stall", d), stall[d], 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      re[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wd[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_vd", vd[d], 0);
      chk("rst_stall", stall[d], 0);
      chk("rst_err", err[d], 0);
      chk("rst_data", rdata[d], 0);
      chk("rst_irq", irq[d], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // write then read, LATENCY=2
    wr(0, 32'h10, 32'hDEAD_BEEF, 0);
    rd(0, 32'h10, 2, 32'hDEAD_BEEF, 0);
    idle(0, 1);

    // back-to-back reads, LATENCY=1, enable held through DONE
    wr(1, 32'h0, 32'd1, 0);
    wr(1, 32'h4, 32'd2, 0);
    rd(1, 32'h0, 1, 32'd1, 0);
    rd(1, 32'h4, 1, 32'd2, 0);
    idle(1, 2);

    // both enables: write commits, read dropped, error
    re[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wd[0] = 32'h55;
    @(negedge clk);
    chk("both_err", err[0], 1);
    @(posedge clk); #1;
    idle(0, 1);
    rd(0, 32'h8, 2, 32'h55, 0);

    // out-of-range accesses; 0x1000 aliases word 0 if the write leaks through
    wr(0, 32'h0, 32'h11, 0);
    wr(0, 32'h1000, 32'h77, 1);
    rd(0, 32'h1000, 2, 32'h0, 1);
    rd(0, 32'h0, 2, 32'h11, 0);
    idle(0, 1);

    // reset while in WAIT
    re[0] = 1'b1; addr[0] = 32'h10;
    @(negedge clk);
    chk("rstw_stall0", stall[0], 1);
    @(posedge clk); #1;
    rst = 1'b1; re[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_stall", stall[0], 0);
    chk("rstw_vd", vd[0], 0);
    chk("rstw_data", rdata[0], 0);
    @(posedge clk); #1;
    idle(0, 1);
    rd(0, 32'h10, 2, 32'hDEAD_BEEF, 0);
    idle(0, 1);

`ifdef DMEM_MMIO_TIMER_EN
    wr(0, 32'hFFFF_FF00, 32'd0, 0);
    wr(0, 32'hFFFF_FF04, 32'd20, 0);
    @(negedge clk);
    chk("irq_early", irq[0], 0);
    @(posedge clk); #1;
    n = 1;
    while (!irq[0] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("irq_rise_window", 32'((n >= 15) && (n <= 25)), 1);
    rd(0, 32'hFFFF_FF04, 2, 32'd20, 0);
    wr(0, 32'hFFFF_FF04, 32'hFFFF_FFFF, 0);
    idle(0, 2);
    @(negedge clk);
    chk("irq_clear", irq[0], 0);
    @(posedge clk); #1;
`else
    n = 0;
    wr(0, 32'hFFFF_FF00, 32'd5, 1);
    rd(0, 32'hFFFF_FF00, 2, 32'd0, 1);
    idle(0, 1);
    repeat (30) begin
      @(negedge clk);
      n += int'(irq[0]) + int'(irq[1]);
    end
    chk("irq_tied", 32'(n), 0);
    @(posedge clk); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
